// File: rtl/mem_pwr_pkg.sv
// Shared definitions for the mem_ctrl power sequencer: state encodings and
// the isolation/power/retention output vector that each state drives.
package mem_pwr_pkg;

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_SAVE    = 3'd1,
        ST_ISO     = 3'd2,
        ST_PWR_OFF = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWR_ON  = 3'd5,
        ST_RESTORE = 3'd6
    } pwr_state_e;

    typedef struct packed {
        logic iso_up;
        logic pwr_up;
        logic save;
        logic restore;
    } pwr_out_t;

    // Bit order: {iso_up, pwr_up, save, restore}
    localparam pwr_out_t OUT_ON      = 4'b0100;
    localparam pwr_out_t OUT_SAVE    = 4'b0110;
    localparam pwr_out_t OUT_ISO     = 4'b1100;
    localparam pwr_out_t OUT_PWR_OFF = 4'b1000;
    localparam pwr_out_t OUT_OFF     = 4'b1000;
    localparam pwr_out_t OUT_PWR_ON  = 4'b1100;
    localparam pwr_out_t OUT_RESTORE = 4'b1101;

    function automatic pwr_out_t state_outputs(input pwr_state_e s);
        pwr_out_t o;
        case (s)
            ST_ON:      o = OUT_ON;
            ST_SAVE:    o = OUT_SAVE;
            ST_ISO:     o = OUT_ISO;
            ST_PWR_OFF: o = OUT_PWR_OFF;
            ST_OFF:     o = OUT_OFF;
            ST_PWR_ON:  o = OUT_PWR_ON;
            ST_RESTORE: o = OUT_RESTORE;
            default:    o = OUT_ON;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_pwr_ctrl_if.sv
// Request/status bundle between the power sequencer and its requester.
interface mem_pwr_ctrl_if;
    logic       pwr_down_req;
    logic       pwr_up_req;
    logic       mem_busy;
    logic       iso_up;
    logic       pwr_up;
    logic       save;
    logic       restore;
    logic       pwr_done;
    logic [2:0] pwr_state;

    modport master (
        output pwr_down_req, pwr_up_req, mem_busy,
        input  iso_up, pwr_up, save, restore, pwr_done, pwr_state
    );

    modport slave (
        input  pwr_down_req, pwr_up_req, mem_busy,
        output iso_up, pwr_up, save, restore, pwr_done, pwr_state
    );
endinterface

// File: rtl/mem_pwr_ctrl_timer.sv
// Phase down-counter: loaded with N-1 on phase entry, counts to zero so a
// phase lasts exactly N cycles.
module pwr_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_pwr_ctrl.sv
// Power sequencer for the mem_ctrl domain: save -> isolate -> power-off and
// power-on -> restore -> de-isolate, with registered outputs.
module mem_pwr_ctrl
    import mem_pwr_pkg::*;
#(
    parameter int SAVE_CYCLES    = 2,
    parameter int ISO_CYCLES     = 1,
    parameter int PWR_CYCLES     = 4,
    parameter int RESTORE_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_pwr_ctrl_if.slave     ctrl_if
);
    localparam logic [CNT_W-1:0] SAVE_LOAD    = CNT_W'(SAVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ISO_LOAD     = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWR_LOAD     = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESTORE_LOAD = CNT_W'(RESTORE_CYCLES - 1);

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    pwr_out_t         outs_q;
    logic             done_q;
    logic             done_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    pwr_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Each timed phase loads the timer for the phase it is about to enter.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            ST_ON: begin
                if (ctrl_if.pwr_down_req && !ctrl_if.mem_busy) begin
                    state_d      = ST_SAVE;
                    tmr_load     = 1'b1;
                    tmr_load_val = SAVE_LOAD;
                end
            end
            ST_SAVE: begin
                if (tmr_zero) begin
                    state_d      = ST_ISO;
                    tmr_load     = 1'b1;
                    tmr_load_val = ISO_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ISO: begin
                if (tmr_zero) begin
                    state_d      = ST_PWR_OFF;
                    tmr_load     = 1'b1;
                    tmr_load_val = PWR_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_PWR_OFF: begin
                if (tmr_zero) begin
                    state_d = ST_OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_OFF: begin
                if (ctrl_if.pwr_up_req) begin
                    state_d      = ST_PWR_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = PWR_LOAD;
                end
            end
            ST_PWR_ON: begin
                if (tmr_zero) begin
                    state_d      = ST_RESTORE;
                    tmr_load     = 1'b1;
                    tmr_load_val = RESTORE_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESTORE: begin
                if (tmr_zero) begin
                    state_d = ST_ON;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_ON;
            end
        endcase
    end

    assign done_d = ((state_q == ST_PWR_OFF) && (state_d == ST_OFF)) ||
                    ((state_q == ST_RESTORE) && (state_d == ST_ON));

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ON;
            outs_q  <= OUT_ON;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outs_q  <= state_outputs(state_d);
            done_q  <= done_d;
        end
    end

    assign ctrl_if.iso_up    = outs_q.iso_up;
    assign ctrl_if.pwr_up    = outs_q.pwr_up;
    assign ctrl_if.save      = outs_q.save;
    assign ctrl_if.restore   = outs_q.restore;
    assign ctrl_if.pwr_done  = done_q;
    assign ctrl_if.pwr_state = state_q;
endmodule

// File: tb/tb_mem_pwr_ctrl.sv
// Directed bench for mem_pwr_ctrl: per-cycle checks of the packed status
// {iso_up, pwr_up, save, restore, pwr_done, pwr_state} through each sequence.
module tb_mem_pwr_ctrl;
    logic clk;
    logic reset;
    logic rst_d = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_pwr_ctrl_if bus();

    mem_pwr_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) rst_d <= reset;

    // Packed status: {iso_up, pwr_up, save, restore, pwr_done, pwr_state[2:0]}
    logic [7:0] obs;
    assign obs = {bus.iso_up, bus.pwr_up, bus.save, bus.restore, bus.pwr_done, bus.pwr_state};

    localparam logic [7:0] E_ON      = 8'b0100_0000;
    localparam logic [7:0] E_ON_DONE = 8'b0100_1000;
    localparam logic [7:0] E_SAVE    = 8'b0110_0001;
    localparam logic [7:0] E_ISO     = 8'b1100_0010;
    localparam logic [7:0] E_PWROFF  = 8'b1000_0011;
    localparam logic [7:0] E_OFF     = 8'b1000_0100;
    localparam logic [7:0] E_OFF_DN  = 8'b1000_1100;
    localparam logic [7:0] E_PWRON   = 8'b1100_0101;
    localparam logic [7:0] E_RESTORE = 8'b1101_0110;

    // Cycles t+1 .. t+9 after pwr_down_req is sampled at edge t.
    localparam logic [7:0] DOWN_SEQ [9] = '{E_SAVE, E_SAVE, E_ISO, E_PWROFF, E_PWROFF,
                                            E_PWROFF, E_PWROFF, E_OFF_DN, E_OFF};
    // Cycles t+1 .. t+8 after pwr_up_req is sampled at edge t.
    localparam logic [7:0] UP_SEQ [8] = '{E_PWRON, E_PWRON, E_PWRON, E_PWRON,
                                          E_RESTORE, E_RESTORE, E_ON_DONE, E_ON};

    a_save_restore: assert property (@(posedge clk) disable iff (reset)
        !(bus.save && bus.restore))
        else begin errors++; $display("FAIL sva_save_restore both high"); end
    a_off_isolated: assert property (@(posedge clk) disable iff (reset)
        !bus.pwr_up |-> bus.iso_up)
        else begin errors++; $display("FAIL sva_iso pwr_up=0 with iso_up=0"); end
    a_iso_release: assert property (@(posedge clk) disable iff (reset || rst_d)
        $fell(bus.iso_up) |-> $past(bus.pwr_state) == 3'd6)
        else begin errors++; $display("FAIL sva_iso_fall outside RESTORE->ON"); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (bus.pwr_state !== target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bus.pwr_state !== target) begin
            errors++;
            $display("FAIL %s wait_state got=%0d want=%0d", tag, bus.pwr_state, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pwr_down_req = 1'b0;
        bus.pwr_up_req   = 1'b0;
        bus.mem_busy     = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== E_ON) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs, E_ON);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== E_ON) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", obs, E_ON);
        end
        $display("test_reset done");
    endtask

    task automatic test_power_down(input string tag);
        bus.mem_busy     = 1'b0;
        bus.pwr_down_req = 1'b1;
        tick();
        bus.pwr_down_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== DOWN_SEQ[i]) begin
                errors++;
                $display("FAIL %s t+%0d got=%b want=%b", tag, i + 1, obs, DOWN_SEQ[i]);
            end
        end
        $display("test_power_down %s done", tag);
    endtask

    task automatic test_power_up(input string tag);
        bus.pwr_up_req = 1'b1;
        tick();
        bus.pwr_up_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs !== UP_SEQ[i]) begin
                errors++;
                $display("FAIL %s t+%0d got=%b want=%b", tag, i + 1, obs, UP_SEQ[i]);
            end
        end
        $display("test_power_up %s done", tag);
    endtask

    task automatic test_busy_hold();
        bus.pwr_down_req = 1'b1;
        bus.mem_busy     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== E_ON) begin
                errors++;
                $display("FAIL busy_hold cyc%0d got=%b want=%b", i, obs, E_ON);
            end
        end
        bus.mem_busy = 1'b0;
        tick();
        bus.pwr_down_req = 1'b0;
        checks++;
        if (obs !== E_SAVE) begin
            errors++;
            $display("FAIL busy_release got=%b want=%b", obs, E_SAVE);
        end
        wait_state(3'd4, 20, "busy_to_off");
        $display("test_busy_hold done");
    endtask

    task automatic test_reset_mid_iso();
        bus.pwr_down_req = 1'b1;
        tick();
        bus.pwr_down_req = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== E_ISO) begin
            errors++;
            $display("FAIL mid_iso_reach got=%b want=%b", obs, E_ISO);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs !== E_ON) begin
            errors++;
            $display("FAIL mid_iso_reset got=%b want=%b", obs, E_ON);
        end
        tick();
        checks++;
        if (obs !== E_ON) begin
            errors++;
            $display("FAIL mid_iso_after got=%b want=%b", obs, E_ON);
        end
        $display("test_reset_mid_iso done");
        test_power_down("after_reset");
    endtask

    task automatic test_ignore_and_both();
        bus.pwr_up_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== E_ON) begin
                errors++;
                $display("FAIL up_in_on cyc%0d got=%b want=%b", i, obs, E_ON);
            end
        end
        bus.pwr_up_req   = 1'b0;
        bus.pwr_down_req = 1'b1;
        tick();
        bus.pwr_down_req = 1'b0;
        wait_state(3'd4, 20, "ignore_to_off");
        tick();
        bus.pwr_down_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== E_OFF) begin
                errors++;
                $display("FAIL down_in_off cyc%0d got=%b want=%b", i, obs, E_OFF);
            end
        end
        bus.pwr_up_req = 1'b1;
        tick();
        bus.pwr_up_req = 1'b0;
        checks++;
        if (obs !== E_PWRON) begin
            errors++;
            $display("FAIL both_in_off got=%b want=%b", obs, E_PWRON);
        end
        // pwr_down_req stays high through the up sequence and must re-trigger.
        wait_state(3'd0, 20, "both_to_on");
        checks++;
        if (obs !== E_ON_DONE) begin
            errors++;
            $display("FAIL both_on_done got=%b want=%b", obs, E_ON_DONE);
        end
        tick();
        bus.pwr_down_req = 1'b0;
        checks++;
        if (obs !== E_SAVE) begin
            errors++;
            $display("FAIL retrigger got=%b want=%b", obs, E_SAVE);
        end
        wait_state(3'd4, 20, "retrigger_to_off");
        $display("test_ignore_and_both done");
    endtask

    initial begin
        test_reset();
        test_power_down("defaults");
        test_power_up("from_off");
        test_busy_hold();
        test_power_up("after_busy");
        test_reset_mid_iso();
        test_power_up("after_mid_iso");
        test_ignore_and_both();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
